// File: rtl/ahb_pkg.sv
// ahb_pkg
// Shared AHB-Lite types and constants for the response multiplexer slice.
//   sel_t         : data-phase slave selection (NONE, SRAM, DFLT)
//   dflt_state_t  : default-slave error FSM states (IDLE, ERR1, ERR2)
//   HRESP_*       : single-bit response encodings
//   HTRANS_*      : master transfer type encodings
//   is_active_xfer: true for NONSEQ/SEQ, the transfers a slave must respond to
package ahb_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        SRAM = 2'd1,
        DFLT = 2'd2
    } sel_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ERR1 = 2'd1,
        ERR2 = 2'd2
    } dflt_state_t;

    localparam logic HRESP_OKAY  = 1'b0;
    localparam logic HRESP_ERROR = 1'b1;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    // IDLE and BUSY never need a response, so only NONSEQ/SEQ count as real transfers.
    function automatic logic is_active_xfer(input logic [1:0] htrans);
        return (htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ);
    endfunction

endpackage

// File: rtl/ahb_default_slave.sv
// ahb_default_slave
// Default slave for the unmapped address region. Any active transfer that
// lands here gets the standard two-cycle AHB ERROR response.
// Ports:
//   hclk, hreset   : bus clock, synchronous active-high reset
//   htrans         : address-phase transfer type
//   hsel_sram      : SRAM select (SRAM wins when both selects are high)
//   hsel_default   : select for the unmapped region
//   hready         : bus-wide HREADY as seen by all slaves
//   dflt_ready     : this slave's HREADYOUT, decoded from the state register
//   dflt_resp      : this slave's HRESP, decoded from the state register
module ahb_default_slave
    import ahb_pkg::*;
(
    input  logic       hclk,
    input  logic       hreset,
    input  logic [1:0] htrans,
    input  logic       hsel_sram,
    input  logic       hsel_default,
    input  logic       hready,
    output logic       dflt_ready,
    output logic       dflt_resp
);

    dflt_state_t state_q;
    dflt_state_t state_d;
    logic        start_err;

    // An error only starts when the address phase is actually accepted, the
    // transfer is real, and the SRAM is not also claiming it.
    assign start_err = hsel_default && !hsel_sram && hready && is_active_xfer(htrans);

    // ERR2 doubles as the accept cycle for the next address, so a back-to-back
    // unmapped transfer goes straight to ERR1 again.
    always_comb begin
        state_d = IDLE;
        case (state_q)
            IDLE:    state_d = start_err ? ERR1 : IDLE;
            ERR1:    state_d = ERR2;
            ERR2:    state_d = start_err ? ERR1 : IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge hclk) begin
        if (hreset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Outputs depend only on the state register, so they are glitch-free.
    always_comb begin
        dflt_ready = 1'b1;
        dflt_resp  = HRESP_OKAY;
        case (state_q)
            ERR1: begin
                dflt_ready = 1'b0;
                dflt_resp  = HRESP_ERROR;
            end
            ERR2: begin
                dflt_ready = 1'b1;
                dflt_resp  = HRESP_ERROR;
            end
            default: begin
                dflt_ready = 1'b1;
                dflt_resp  = HRESP_OKAY;
            end
        endcase
    end

endmodule

// File: rtl/ahb_resp_mux.sv
// ahb_resp_mux
// AHB-Lite data-phase response multiplexer for one SRAM slave plus an
// embedded default (error) slave.
// Ports:
//   HCLK, HRESET      : bus clock, synchronous active-high reset
//   HTRANS            : address-phase transfer type
//   HSEL_SRAM         : address-phase select for the SRAM
//   HSEL_DEFAULT      : address-phase select for the unmapped region
//   HRDATA_SRAM       : SRAM read data
//   HREADYOUT_SRAM    : SRAM ready
//   HRESP_SRAM        : SRAM response
//   HRDATA            : read data to the master
//   HREADY            : bus ready to the master and all slaves
//   HRESP             : response to the master
//   SEL_ERR           : sticky flag, both selects seen high on an accepted phase
module ahb_resp_mux
    import ahb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic              HCLK,
    input  logic              HRESET,
    input  logic [1:0]        HTRANS,
    input  logic              HSEL_SRAM,
    input  logic              HSEL_DEFAULT,
    input  logic [DATA_W-1:0] HRDATA_SRAM,
    input  logic              HREADYOUT_SRAM,
    input  logic              HRESP_SRAM,
    output logic [DATA_W-1:0] HRDATA,
    output logic              HREADY,
    output logic              HRESP,
    output logic              SEL_ERR
);

    sel_t sel_q;
    sel_t sel_d;
    logic sel_err_q;
    logic dflt_ready;
    logic dflt_resp;

    ahb_default_slave u_default_slave (
        .hclk         (HCLK),
        .hreset       (HRESET),
        .htrans       (HTRANS),
        .hsel_sram    (HSEL_SRAM),
        .hsel_default (HSEL_DEFAULT),
        .hready       (HREADY),
        .dflt_ready   (dflt_ready),
        .dflt_resp    (dflt_resp)
    );

    // SRAM has priority so a decoder fault never diverts a legitimate SRAM access.
    always_comb begin
        sel_d = NONE;
        if (HSEL_SRAM) begin
            sel_d = SRAM;
        end else if (HSEL_DEFAULT) begin
            sel_d = DFLT;
        end
    end

    // The data-phase owner only advances on an accepted address phase, so it is
    // held across any number of wait states.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            sel_q     <= NONE;
            sel_err_q <= 1'b0;
        end else if (HREADY) begin
            sel_q <= sel_d;
            if (HSEL_SRAM && HSEL_DEFAULT) begin
                sel_err_q <= 1'b1;
            end
        end
    end

    assign SEL_ERR = sel_err_q;

    // Purely combinational from registered state, so the SRAM path adds no latency.
    always_comb begin
        HRDATA = '0;
        HREADY = 1'b1;
        HRESP  = HRESP_OKAY;
        case (sel_q)
            SRAM: begin
                HRDATA = HRDATA_SRAM;
                HREADY = HREADYOUT_SRAM;
                HRESP  = HRESP_SRAM;
            end
            DFLT: begin
                HREADY = dflt_ready;
                HRESP  = dflt_resp;
            end
            default: begin
                HRDATA = '0;
                HREADY = 1'b1;
                HRESP  = HRESP_OKAY;
            end
        endcase
    end

endmodule

// File: tb/tb_ahb_resp_mux.sv
// tb_ahb_resp_mux
// Self-checking bench for ahb_resp_mux. Each call to applyStimulus presents
// one cycle of bus inputs and pushes the outputs expected during that cycle
// onto a scoreboard queue; a monitor pops and compares them on the falling edge.
module tb_ahb_resp_mux;

    localparam int DATA_W = 32;

    typedef struct {
        int              step;
        logic [DATA_W-1:0] rdata;
        logic            ready;
        logic            resp;
        logic            sel_err;
    } exp_t;

    logic              clk;
    logic              reset;
    logic [1:0]        htrans;
    logic              hsel_sram;
    logic              hsel_default;
    logic [DATA_W-1:0] hrdata_sram;
    logic              hreadyout_sram;
    logic              hresp_sram;
    logic [DATA_W-1:0] hrdata;
    logic              hready;
    logic              hresp;
    logic              sel_err;

    exp_t expQ[$];
    int   checkCount = 0;
    int   passCount  = 0;
    int   stepNum    = 0;

    ahb_resp_mux #(.DATA_W(DATA_W)) dut (
        .HCLK           (clk),
        .HRESET         (reset),
        .HTRANS         (htrans),
        .HSEL_SRAM      (hsel_sram),
        .HSEL_DEFAULT   (hsel_default),
        .HRDATA_SRAM    (hrdata_sram),
        .HREADYOUT_SRAM (hreadyout_sram),
        .HRESP_SRAM     (hresp_sram),
        .HRDATA         (hrdata),
        .HREADY         (hready),
        .HRESP          (hresp),
        .SEL_ERR        (sel_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [DATA_W-1:0] got,
                               input logic [DATA_W-1:0] exp);
        checkCount++;
        if (got === exp) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Present one cycle of inputs just after the rising edge; if chk is set,
    // queue the outputs expected while these inputs are applied.
    task automatic applyStimulus(input logic rst, input logic [1:0] tr,
                                 input logic hs, input logic hd,
                                 input logic [DATA_W-1:0] rd, input logic rdy,
                                 input logic rsp, input logic chk,
                                 input logic [DATA_W-1:0] eData, input logic eReady,
                                 input logic eResp, input logic eSelErr);
        exp_t e;
        @(posedge clk);
        #1;
        reset          = rst;
        htrans         = tr;
        hsel_sram      = hs;
        hsel_default   = hd;
        hrdata_sram    = rd;
        hreadyout_sram = rdy;
        hresp_sram     = rsp;
        if (chk) begin
            e.step    = stepNum;
            e.rdata   = eData;
            e.ready   = eReady;
            e.resp    = eResp;
            e.sel_err = eSelErr;
            expQ.push_back(e);
        end
        stepNum++;
    endtask

    // Monitor: compares DUT outputs mid-cycle against the oldest expectation.
    always @(negedge clk) begin
        if (expQ.size() > 0) begin
            exp_t e;
            e = expQ.pop_front();
            checkOutput($sformatf("step%0d.HRDATA", e.step), hrdata, e.rdata);
            checkOutput($sformatf("step%0d.HREADY", e.step), {31'd0, hready}, {31'd0, e.ready});
            checkOutput($sformatf("step%0d.HRESP", e.step), {31'd0, hresp}, {31'd0, e.resp});
            checkOutput($sformatf("step%0d.SEL_ERR", e.step), {31'd0, sel_err}, {31'd0, e.sel_err});
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [DATA_W-1:0] BG = 32'h1234_5678;

    initial begin
        reset = 1'b1; htrans = T_IDLE; hsel_sram = 1'b0; hsel_default = 1'b0;
        hrdata_sram = BG; hreadyout_sram = 1'b1; hresp_sram = 1'b0;

        // Reset, then the reset-state outputs.
        applyStimulus(1, T_IDLE,   0, 0, BG, 1, 0, 0, 32'h0, 1, 0, 0);
        applyStimulus(1, T_IDLE,   0, 0, BG, 1, 0, 1, 32'h0, 1, 0, 0);
        // SRAM read: address phase then data phase with zero latency.
        applyStimulus(0, T_NONSEQ, 1, 0, 32'hDEAD_BEEF, 1, 0, 1, 32'h0, 1, 0, 0);
        applyStimulus(0, T_IDLE,   0, 0, 32'hDEAD_BEEF, 1, 0, 1, 32'hDEAD_BEEF, 1, 0, 0);
        // SRAM wait states with an unmapped address presented meanwhile.
        applyStimulus(0, T_NONSEQ, 1, 0, 32'hDEAD_BEEF, 1, 0, 1, 32'h0, 1, 0, 0);
        applyStimulus(0, T_NONSEQ, 0, 1, 32'hAAAA_5555, 0, 0, 1, 32'hAAAA_5555, 0, 0, 0);
        applyStimulus(0, T_NONSEQ, 0, 1, 32'hAAAA_5555, 0, 0, 1, 32'hAAAA_5555, 0, 0, 0);
        applyStimulus(0, T_NONSEQ, 0, 1, 32'hAAAA_5555, 0, 0, 1, 32'hAAAA_5555, 0, 0, 0);
        // SRAM completes; the held unmapped address is accepted now.
        applyStimulus(0, T_NONSEQ, 0, 1, 32'hCAFE_F00D, 1, 0, 1, 32'hCAFE_F00D, 1, 0, 0);
        // Two-cycle error response, then back to OKAY.
        applyStimulus(0, T_IDLE,   0, 0, BG, 1, 0, 1, 32'h0, 0, 1, 0);
        applyStimulus(0, T_IDLE,   0, 0, BG, 1, 0, 1, 32'h0, 1, 1, 0);
        applyStimulus(0, T_IDLE,   0, 0, BG, 1, 0, 1, 32'h0, 1, 0, 0);
        // Back-to-back unmapped transfers; second accepted during ERR2.
        applyStimulus(0, T_NONSEQ, 0, 1, BG, 1, 0, 1, 32'h0, 1, 0, 0);
        applyStimulus(0, T_NONSEQ, 0, 1, BG, 1, 0, 1, 32'h0, 0, 1, 0);
        applyStimulus(0, T_NONSEQ, 0, 1, BG, 1, 0, 1, 32'h0, 1, 1, 0);
        applyStimulus(0, T_IDLE,   0, 0, BG, 1, 0, 1, 32'h0, 0, 1, 0);
        applyStimulus(0, T_IDLE,   0, 0, BG, 1, 0, 1, 32'h0, 1, 1, 0);
        applyStimulus(0, T_IDLE,   0, 0, BG, 1, 0, 1, 32'h0, 1, 0, 0);
        // Reset while in ERR1 aborts the error.
        applyStimulus(0, T_NONSEQ, 0, 1, BG, 1, 0, 1, 32'h0, 1, 0, 0);
        applyStimulus(1, T_IDLE,   0, 0, BG, 1, 0, 1, 32'h0, 0, 1, 0);
        applyStimulus(0, T_IDLE,   0, 0, BG, 1, 0, 1, 32'h0, 1, 0, 0);
        applyStimulus(0, T_IDLE,   0, 0, BG, 1, 0, 1, 32'h0, 1, 0, 0);
        // Both selects high: SRAM wins, SEL_ERR sets and sticks.
        applyStimulus(0, T_NONSEQ, 1, 1, BG, 1, 0, 1, 32'h0, 1, 0, 0);
        applyStimulus(0, T_IDLE,   0, 0, 32'h0BAD_F00D, 1, 0, 1, 32'h0BAD_F00D, 1, 0, 1);
        applyStimulus(0, T_IDLE,   0, 0, BG, 1, 0, 1, 32'h0, 1, 0, 1);
        // SRAM-driven two-cycle error passes straight through.
        applyStimulus(0, T_NONSEQ, 1, 0, BG, 1, 0, 1, 32'h0, 1, 0, 1);
        applyStimulus(0, T_IDLE,   0, 0, 32'h1111_1111, 0, 1, 1, 32'h1111_1111, 0, 1, 1);
        applyStimulus(0, T_IDLE,   0, 0, 32'h1111_1111, 1, 1, 1, 32'h1111_1111, 1, 1, 1);
        // Reset clears the sticky flag.
        applyStimulus(1, T_IDLE,   0, 0, BG, 1, 0, 1, 32'h0, 1, 0, 1);
        applyStimulus(0, T_IDLE,   0, 0, BG, 1, 0, 1, 32'h0, 1, 0, 0);
        // Default slave selected with an IDLE transfer: OKAY, no error.
        applyStimulus(0, T_IDLE,   0, 1, BG, 1, 0, 1, 32'h0, 1, 0, 0);
        applyStimulus(0, T_IDLE,   0, 0, BG, 1, 0, 1, 32'h0, 1, 0, 0);
        applyStimulus(0, T_IDLE,   0, 0, BG, 1, 0, 1, 32'h0, 1, 0, 0);

        // Let the monitor drain the last expectation.
        @(posedge clk);
        @(posedge clk);
        checkOutput("scoreboard.empty", expQ.size(), 32'd0);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
